// File: rtl/shift_lr_iter.sv
// Iterative left/right, logical/arithmetic shifter: one binary stage (1,2,4,..) per clock.
// Latency: START accepted at edge k, Z and DONE update at edge k+SHW, DONE low again at k+SHW+1.
// Backpressure: START is ignored while BUSY=1; a new START is accepted in IDLE or in the DONE (FIN) cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset; aborts any in-flight request
//   START  request strobe, sampled only when BUSY=0
//   X      operand, captured on an accepted START
//   S      shift amount 0..WIDTH-1, captured on an accepted START
//   LEFT   1 = shift left, 0 = shift right, captured on an accepted START
//   LOG    1 = logical, 0 = arithmetic (right shifts only), captured on an accepted START
//   Z      result, valid from the DONE cycle until the next DONE
//   BUSY   request in progress
//   DONE   one-cycle pulse marking Z valid
module shift_lr_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [SHW-1:0]   S,
  input  logic             LEFT,
  input  logic             LOG,
  output logic [WIDTH-1:0] Z,
  output logic             BUSY,
  output logic             DONE
);

  // Stage counter only needs to index the SHW bits of the shift amount.
  localparam int            CW   = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CW-1:0] LAST = CW'(SHW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] stage_res;
  logic [SHW-1:0]   s_q;
  logic             left_q;
  logic             log_q;
  logic [CW-1:0]    stage;
  logic             accept;
  logic             last_stage;

  // Shift by a fixed power-of-two amount. Arithmetic right replicates the
  // current MSB, so the sign survives across successive stages.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] a,
    input int               amt,
    input logic             left,
    input logic             lg
  );
    logic signed [WIDTH-1:0] sa;
    sa = a;
    if (left)
      return a << amt;
    else if (lg)
      return a >> amt;
    else
      return sa >>> amt;
  endfunction

  // Result of the current stage: each stage selects one constant shift, so
  // the datapath is a small mux of fixed wirings rather than a barrel shifter.
  always_comb begin
    stage_res = acc;
    for (int i = 0; i < SHW; i++) begin
      if (stage == CW'(i) && s_q[i])
        stage_res = shift_by(acc, 1 << i, left_q, log_q);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_stage = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (stage == LAST) begin
          last_stage = 1'b1;
          state_nxt  = FIN;
        end
      end
      FIN: begin
        DONE = 1'b1;
        // Back-to-back: the DONE cycle also accepts the next request.
        if (START) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      s_q    <= '0;
      left_q <= 1'b0;
      log_q  <= 1'b0;
      stage  <= '0;
      Z      <= '0;
    end else if (accept) begin
      acc    <= X;
      s_q    <= S;
      left_q <= LEFT;
      log_q  <= LOG;
      stage  <= '0;
    end else if (state == SHIFT) begin
      acc   <= stage_res;
      stage <= stage + CW'(1);
      // Z is only touched on the completing edge so it holds the previous
      // result throughout the next request.
      if (last_stage)
        Z <= stage_res;
    end
  end

endmodule
